// File: rtl/axi4l_master_engine.sv
`default_nettype none
// ============================================================================
// axi4l_master_engine : command/response stream to AXI4-Lite master, one
// transaction in flight. Optional hang timeout via AXI4L_MASTER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module axi4l_master_engine #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_timeout,
   output logic [ADDR_WIDTH-1:0]     m_awaddr,
   output logic [2:0]                m_awprot,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [DATA_WIDTH-1:0]     m_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_wstrb,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   input  logic [1:0]                m_bresp,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   output logic [ADDR_WIDTH-1:0]     m_araddr,
   output logic [2:0]                m_arprot,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   input  logic [DATA_WIDTH-1:0]     m_rdata,
   input  logic [1:0]                m_rresp,
   input  logic                      m_rvalid,
   output logic                      m_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
      $error("axi4l_master_engine: DATA_WIDTH must be 32 or 64");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("axi4l_master_engine: TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_DATA = 3'd4,
      S_RSP     = 3'd5
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_cmd_ready, w_cmd_ready_nxt;
   logic [ADDR_WIDTH-1:0]   r_awaddr, w_awaddr_nxt;
   logic [ADDR_WIDTH-1:0]   r_araddr, w_araddr_nxt;
   logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
   logic [STRB_WIDTH-1:0]   r_wstrb, w_wstrb_nxt;
   logic                    r_awvalid, w_awvalid_nxt;
   logic                    r_wvalid, w_wvalid_nxt;
   logic                    r_bready, w_bready_nxt;
   logic                    r_arvalid, w_arvalid_nxt;
   logic                    r_rready, w_rready_nxt;
   logic                    r_aw_done, w_aw_done_nxt;
   logic                    r_w_done, w_w_done_nxt;
   logic                    r_rsp_valid, w_rsp_valid_nxt;
   logic                    r_rsp_write, w_rsp_write_nxt;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
   logic [1:0]              r_rsp_resp, w_rsp_resp_nxt;
   logic                    r_rsp_timeout, w_rsp_timeout_nxt;

   logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rsp_hs;
   logic w_tmo_hit;

   assign w_cmd_hs = cmd_valid & r_cmd_ready;
   assign w_aw_hs  = r_awvalid & m_awready;
   assign w_w_hs   = r_wvalid & m_wready;
   assign w_b_hs   = r_bready & m_bvalid;
   assign w_ar_hs  = r_arvalid & m_arready;
   assign w_r_hs   = r_rready & m_rvalid;
   assign w_rsp_hs = r_rsp_valid & rsp_ready;

`ifdef AXI4L_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_busy;
   logic             w_any_hs;

   assign w_busy   = (r_state == S_WR) || (r_state == S_WR_RESP) ||
                     (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
   assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

   // Idle/RSP hold the counter at zero, so entering a busy state starts from zero.
   always_ff @(posedge aclk) begin
      if (areset || !w_busy || w_any_hs) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
   end

   assign w_tmo_hit = w_busy && !w_any_hs && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_comb begin
      w_state_nxt       = r_state;
      w_cmd_ready_nxt   = r_cmd_ready;
      w_awaddr_nxt      = r_awaddr;
      w_araddr_nxt      = r_araddr;
      w_wdata_nxt       = r_wdata;
      w_wstrb_nxt       = r_wstrb;
      w_awvalid_nxt     = r_awvalid;
      w_wvalid_nxt      = r_wvalid;
      w_bready_nxt      = r_bready;
      w_arvalid_nxt     = r_arvalid;
      w_rready_nxt      = r_rready;
      w_aw_done_nxt     = r_aw_done | w_aw_hs;
      w_w_done_nxt      = r_w_done | w_w_hs;
      w_rsp_valid_nxt   = r_rsp_valid;
      w_rsp_write_nxt   = r_rsp_write;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_resp_nxt    = r_rsp_resp;
      w_rsp_timeout_nxt = r_rsp_timeout;

      unique case (r_state)
         S_IDLE: begin
            if (w_cmd_hs) begin
               w_cmd_ready_nxt = 1'b0;
               w_rsp_write_nxt = cmd_write;
               if (cmd_write) begin
                  w_awaddr_nxt  = cmd_addr;
                  w_wdata_nxt   = cmd_wdata;
                  w_wstrb_nxt   = cmd_wstrb;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
                  w_aw_done_nxt = 1'b0;
                  w_w_done_nxt  = 1'b0;
                  w_state_nxt   = S_WR;
               end else begin
                  w_araddr_nxt  = cmd_addr;
                  w_arvalid_nxt = 1'b1;
                  w_state_nxt   = S_RD_ADDR;
               end
            end
         end
         S_WR: begin
            if (w_aw_hs) w_awvalid_nxt = 1'b0;
            if (w_w_hs)  w_wvalid_nxt  = 1'b0;
            if (w_aw_done_nxt && w_w_done_nxt) begin
               w_bready_nxt = 1'b1;
               w_state_nxt  = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (w_b_hs) begin
               w_bready_nxt      = 1'b0;
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_resp_nxt    = m_bresp;
               w_rsp_rdata_nxt   = '0;
               w_rsp_timeout_nxt = 1'b0;
               w_state_nxt       = S_RSP;
            end
         end
         S_RD_ADDR: begin
            if (w_ar_hs) begin
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
               w_state_nxt   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (w_r_hs) begin
               w_rready_nxt      = 1'b0;
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_resp_nxt    = m_rresp;
               w_rsp_rdata_nxt   = m_rdata;
               w_rsp_timeout_nxt = 1'b0;
               w_state_nxt       = S_RSP;
            end
         end
         S_RSP: begin
            if (w_rsp_hs) begin
               w_rsp_valid_nxt = 1'b0;
               w_cmd_ready_nxt = 1'b1;
               w_state_nxt     = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Abort: withdraw every AXI request and report SLVERR with no data.
      if (w_tmo_hit) begin
         w_awvalid_nxt     = 1'b0;
         w_wvalid_nxt      = 1'b0;
         w_bready_nxt      = 1'b0;
         w_arvalid_nxt     = 1'b0;
         w_rready_nxt      = 1'b0;
         w_rsp_valid_nxt   = 1'b1;
         w_rsp_timeout_nxt = 1'b1;
         w_rsp_resp_nxt    = 2'b10;
         w_rsp_rdata_nxt   = '0;
         w_state_nxt       = S_RSP;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state       <= S_IDLE;
         r_cmd_ready   <= 1'b1;
         r_awaddr      <= '0;
         r_araddr      <= '0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_write   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= 2'b00;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cmd_ready   <= w_cmd_ready_nxt;
         r_awaddr      <= w_awaddr_nxt;
         r_araddr      <= w_araddr_nxt;
         r_wdata       <= w_wdata_nxt;
         r_wstrb       <= w_wstrb_nxt;
         r_awvalid     <= w_awvalid_nxt;
         r_wvalid      <= w_wvalid_nxt;
         r_bready      <= w_bready_nxt;
         r_arvalid     <= w_arvalid_nxt;
         r_rready      <= w_rready_nxt;
         r_aw_done     <= w_aw_done_nxt;
         r_w_done      <= w_w_done_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_write   <= w_rsp_write_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_resp    <= w_rsp_resp_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_write   = r_rsp_write;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_resp    = r_rsp_resp;
   assign rsp_timeout = r_rsp_timeout;
   assign m_awaddr    = r_awaddr;
   assign m_awprot    = 3'b000;
   assign m_awvalid   = r_awvalid;
   assign m_wdata     = r_wdata;
   assign m_wstrb     = r_wstrb;
   assign m_wvalid    = r_wvalid;
   assign m_bready    = r_bready;
   assign m_araddr    = r_araddr;
   assign m_arprot    = 3'b000;
   assign m_arvalid   = r_arvalid;
   assign m_rready    = r_rready;

endmodule
`default_nettype wire
